// File: rtl/hline_span_sched_if.sv
// Command and engine-side signal bundle for the horizontal-line span scheduler.
// slave = scheduler view, master = command source / engine view.
interface hline_span_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_fb_base;
    logic [31:0] cmd_zb_base;
    logic [15:0] cmd_y;
    logic [15:0] cmd_x1;
    logic [15:0] cmd_x2;
    logic [31:0] cmd_z1;
    logic [31:0] cmd_z2;
    logic [31:0] cmd_slope;
    logic        eng_start;
    logic [31:0] eng_fb_addr;
    logic [31:0] eng_zb_addr;
    logic [8:0]  eng_len;
    logic [31:0] eng_z0;
    logic [31:0] eng_slope;
    logic        eng_done;
    logic        busy;
    logic        line_done;

    modport slave (
        input  cmd_valid, cmd_fb_base, cmd_zb_base, cmd_y, cmd_x1, cmd_x2,
               cmd_z1, cmd_z2, cmd_slope, eng_done,
        output cmd_ready, eng_start, eng_fb_addr, eng_zb_addr, eng_len,
               eng_z0, eng_slope, busy, line_done
    );

    modport master (
        output cmd_valid, cmd_fb_base, cmd_zb_base, cmd_y, cmd_x1, cmd_x2,
               cmd_z1, cmd_z2, cmd_slope, eng_done,
        input  cmd_ready, eng_start, eng_fb_addr, eng_zb_addr, eng_len,
               eng_z0, eng_slope, busy, line_done
    );
endinterface

// File: rtl/hline_span_sched.sv
// Horizontal-line span scheduler: normalizes a line command left-to-right and
// feeds it to the z-buffer engine in bursts of up to MAX_BURST pixels.
module hline_span_sched #(
    parameter int MAX_BURST = 256,
    parameter int PIX_BYTES = 4,
    parameter int STRIDE    = 2560
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    hline_span_sched_if.slave    io_bus
);
    localparam int          LOG2_B  = $clog2(MAX_BURST);
    localparam logic [16:0] BURST17 = 17'(MAX_BURST);
    localparam logic [31:0] STEP    = 32'(MAX_BURST * PIX_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_fb_base, r_zb_base;
    logic [15:0] r_y, r_xl;
    logic [31:0] r_zl, r_slope;
    logic [16:0] r_rem;
    logic [8:0]  r_len;
    logic [31:0] r_fb_cur, r_zb_cur, r_z_cur;
    logic        r_line_done;

    logic        w_fwd;
    logic [15:0] w_xl;
    logic [31:0] w_zl;
    logic [16:0] w_cnt;
    logic [31:0] w_row_off, w_col_off;
    logic [16:0] w_rem_nxt;
    logic [31:0] w_z_step;

    function automatic logic [8:0] burst_len(input logic [16:0] rem);
        return (rem > BURST17) ? BURST17[8:0] : rem[8:0];
    endfunction

    assign w_fwd     = (io_bus.cmd_x1 <= io_bus.cmd_x2);
    assign w_xl      = w_fwd ? io_bus.cmd_x1 : io_bus.cmd_x2;
    assign w_zl      = w_fwd ? io_bus.cmd_z1 : io_bus.cmd_z2;
    // 17-bit span so a full 0..65535 line (65536 pixels) still fits
    assign w_cnt     = w_fwd ? ({1'b0, io_bus.cmd_x2} - {1'b0, io_bus.cmd_x1} + 17'd1)
                             : ({1'b0, io_bus.cmd_x1} - {1'b0, io_bus.cmd_x2} + 17'd1);
    assign w_row_off = 32'(r_y) * 32'(STRIDE);
    assign w_col_off = 32'(r_xl) * 32'(PIX_BYTES);
    assign w_rem_nxt = r_rem - {8'd0, r_len};
    assign w_z_step  = r_slope << LOG2_B;

    // Latch, normalize, and walk the line burst by burst
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_fb_base   <= '0;
            r_zb_base   <= '0;
            r_y         <= '0;
            r_xl        <= '0;
            r_zl        <= '0;
            r_slope     <= '0;
            r_rem       <= '0;
            r_len       <= '0;
            r_fb_cur    <= '0;
            r_zb_cur    <= '0;
            r_z_cur     <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.cmd_valid) begin
                        r_fb_base <= io_bus.cmd_fb_base;
                        r_zb_base <= io_bus.cmd_zb_base;
                        r_y       <= io_bus.cmd_y;
                        r_xl      <= w_xl;
                        r_zl      <= w_zl;
                        r_slope   <= io_bus.cmd_slope;
                        r_rem     <= w_cnt;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_fb_cur <= r_fb_base + w_row_off + w_col_off;
                    r_zb_cur <= r_zb_base + w_row_off + w_col_off;
                    r_z_cur  <= r_zl;
                    r_len    <= burst_len(r_rem);
                    r_state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (io_bus.eng_done) begin
                        r_rem    <= w_rem_nxt;
                        r_fb_cur <= r_fb_cur + STEP;
                        r_zb_cur <= r_zb_cur + STEP;
                        r_z_cur  <= r_z_cur + w_z_step;
                        r_len    <= burst_len(w_rem_nxt);
                        if (w_rem_nxt != 17'd0) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_line_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.cmd_ready   = (r_state == S_IDLE);
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.eng_start   = (r_state == S_ISSUE);
    assign io_bus.eng_fb_addr = r_fb_cur;
    assign io_bus.eng_zb_addr = r_zb_cur;
    assign io_bus.eng_len     = r_len;
    assign io_bus.eng_z0      = r_z_cur;
    assign io_bus.eng_slope   = r_slope;
    assign io_bus.line_done   = r_line_done;
endmodule

// File: tb/tb_hline_span_sched.sv
// Directed bench for hline_span_sched; expected bursts are queued as commands
// are driven and checked in order whenever the engine start pulses.
module tb_hline_span_sched;
    logic clk = 1'b0;
    logic reset;
    hline_span_sched_if bus();

    hline_span_sched #(.MAX_BURST(256), .PIX_BYTES(4), .STRIDE(2560)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  len;
        logic [31:0] fb;
        logic [31:0] zb;
        logic [31:0] z0;
        logic [31:0] slope;
    } burst_t;

    burst_t exp_q[$];
    int n_chk   = 0;
    int n_pass  = 0;
    int n_start = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: split a line into expected bursts
    task automatic push_line(input logic [31:0] fb, input logic [31:0] zb, input logic [15:0] y,
                             input logic [15:0] x1, input logic [15:0] x2,
                             input logic [31:0] z1, input logic [31:0] z2, input logic [31:0] slope);
        logic [15:0] xl;
        logic [31:0] z, off;
        int rem;
        burst_t b;
        xl  = (x1 <= x2) ? x1 : x2;
        z   = (x1 <= x2) ? z1 : z2;
        rem = (x1 <= x2) ? (int'(x2) - int'(x1) + 1) : (int'(x1) - int'(x2) + 1);
        off = 32'(y) * 32'd2560 + 32'(xl) * 32'd4;
        while (rem > 0) begin
            b.len   = (rem > 256) ? 9'd256 : 9'(rem);
            b.fb    = fb + off;
            b.zb    = zb + off;
            b.z0    = z;
            b.slope = slope;
            exp_q.push_back(b);
            rem = rem - int'(b.len);
            off = off + 32'd1024;
            z   = z + slope * 32'd256;
        end
    endtask

    task automatic set_cmd(input logic [31:0] fb, input logic [31:0] zb, input logic [15:0] y,
                           input logic [15:0] x1, input logic [15:0] x2,
                           input logic [31:0] z1, input logic [31:0] z2, input logic [31:0] slope);
        bus.cmd_fb_base = fb; bus.cmd_zb_base = zb; bus.cmd_y = y;
        bus.cmd_x1 = x1; bus.cmd_x2 = x2; bus.cmd_z1 = z1; bus.cmd_z2 = z2;
        bus.cmd_slope = slope;
        push_line(fb, zb, y, x1, x2, z1, z2, slope);
    endtask

    // Present command for one edge, then confirm SETUP and start at T+2
    task automatic send(input logic [31:0] fb, input logic [31:0] zb, input logic [15:0] y,
                        input logic [15:0] x1, input logic [15:0] x2,
                        input logic [31:0] z1, input logic [31:0] z2, input logic [31:0] slope);
        set_cmd(fb, zb, y, x1, x2, z1, z2, slope);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("setup_ready", 64'(bus.cmd_ready), 64'd0);
        chk("setup_start", 64'(bus.eng_start), 64'd0);
        tick();
        chk("start_T2", 64'(bus.eng_start), 64'd1);
    endtask

    // From a start cycle: wait in WAIT, pulse done, land on cycle D+1
    task automatic done_pulse();
        tick();
        tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
    endtask

    task automatic run_bursts(input int nb);
        for (int k = 0; k < nb; k++) begin
            done_pulse();
            if (k < nb - 1) begin
                chk("next_start", 64'(bus.eng_start), 64'd1);
                chk("mid_line_done", 64'(bus.line_done), 64'd0);
            end else begin
                chk("line_done", 64'(bus.line_done), 64'd1);
                chk("end_start", 64'(bus.eng_start), 64'd0);
                chk("end_ready", 64'(bus.cmd_ready), 64'd1);
            end
        end
    endtask

    // Scoreboard: every start must match the next expected burst
    always @(negedge clk) begin
        if (bus.eng_start === 1'b1) begin
            burst_t e;
            n_start++;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("eng_len", 64'(bus.eng_len), 64'(e.len));
                chk("eng_fb_addr", 64'(bus.eng_fb_addr), 64'(e.fb));
                chk("eng_zb_addr", 64'(bus.eng_zb_addr), 64'(e.zb));
                chk("eng_z0", 64'(bus.eng_z0), 64'(e.z0));
                chk("eng_slope", 64'(bus.eng_slope), 64'(e.slope));
            end
        end
    end

    initial begin
        int starts_before;
        logic seen_ld;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.eng_done = 1'b0;
        bus.cmd_fb_base = '0; bus.cmd_zb_base = '0; bus.cmd_y = '0;
        bus.cmd_x1 = '0; bus.cmd_x2 = '0; bus.cmd_z1 = '0; bus.cmd_z2 = '0; bus.cmd_slope = '0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_start", 64'(bus.eng_start), 64'd0);
        chk("rst_line_done", 64'(bus.line_done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_fb", 64'(bus.eng_fb_addr), 64'd0);
        chk("rst_zb", 64'(bus.eng_zb_addr), 64'd0);
        chk("rst_len", 64'(bus.eng_len), 64'd0);
        chk("rst_z0", 64'(bus.eng_z0), 64'd0);
        chk("rst_slope", 64'(bus.eng_slope), 64'd0);

        // eng_done while idle is ignored
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        repeat (3) tick();
        chk("idle_done_busy", 64'(bus.busy), 64'd0);
        chk("idle_done_starts", 64'(n_start), 64'd0);

        // Short line
        send(32'h1000_0000, 32'h2000_0000, 16'd2, 16'd10, 16'd19, 32'd100, 32'd145, 32'd5);
        tick();
        chk("wait_start_low", 64'(bus.eng_start), 64'd0);
        chk("wait_busy", 64'(bus.busy), 64'd1);
        done_pulse();
        chk("short_line_done", 64'(bus.line_done), 64'd1);
        chk("short_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("line_done_pulse", 64'(bus.line_done), 64'd0);

        // Reversed multi-burst
        send(32'h3000_0000, 32'h4000_0000, 16'd0, 16'd600, 16'd0, 32'd7, 32'd1000, 32'd2);
        run_bursts(3);

        // Single pixel
        send(32'h0, 32'h0, 16'd1, 16'd5, 16'd5, 32'd9, 32'd9, 32'hFFFF_FFFF);
        run_bursts(1);

        // Reset mid-WAIT of burst 2, coincident with eng_done
        send(32'h5000_0000, 32'h6000_0000, 16'd4, 16'd0, 16'd599, 32'd50, 32'd0, 32'd1);
        done_pulse();
        chk("rst2_second_start", 64'(bus.eng_start), 64'd1);
        tick();
        reset = 1'b1;
        bus.eng_done = 1'b1;
        tick();
        reset = 1'b0;
        bus.eng_done = 1'b0;
        chk("rst2_busy", 64'(bus.busy), 64'd0);
        chk("rst2_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst2_len", 64'(bus.eng_len), 64'd0);
        chk("rst2_fb", 64'(bus.eng_fb_addr), 64'd0);
        chk("rst2_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        starts_before = n_start;
        seen_ld = 1'b0;
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.line_done !== 1'b0) seen_ld = 1'b1;
            tick();
        end
        chk("rst2_no_line_done", 64'(seen_ld), 64'd0);
        chk("rst2_no_start", 64'(n_start), 64'(starts_before));

        // Back-to-back: second command held valid while first runs
        set_cmd(32'h7000_0000, 32'h7100_0000, 16'd3, 16'd0, 16'd9, 32'd11, 32'd0, 32'd3);
        bus.cmd_valid = 1'b1;
        tick();
        set_cmd(32'h8000_0000, 32'h8100_0000, 16'd5, 16'd20, 16'd1, 32'd0, 32'd77, 32'd4);
        chk("b2b_setup_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        chk("b2b_start_a", 64'(bus.eng_start), 64'd1);
        tick();
        chk("b2b_wait_ready", 64'(bus.cmd_ready), 64'd0);
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        chk("b2b_line_done", 64'(bus.line_done), 64'd1);
        chk("b2b_ready_D1", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_accepted_D2", 64'(bus.cmd_ready), 64'd0);
        chk("b2b_no_start_D2", 64'(bus.eng_start), 64'd0);
        tick();
        chk("b2b_start_D3", 64'(bus.eng_start), 64'd1);
        run_bursts(1);

        repeat (2) tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
